ttlx8_out_stage: RTL and testbench

//  Output stage directly downstream of the real-time output buffer core.
//  - Consumes each matched event: {64-bit timestamp, 8-bit TTL data} plus its one-cycle strobe.
//  - Drives the 8 physical TTL pins, with per-channel pulse mode, override and polarity.
//  - Keeps an event counter, the last-fired timestamp and sticky copies of the buffer's error strobes.

---
 rtl/ttlx8_out_stage_if.sv | 12 +
 rtl/ttlx8_out_stage.sv | 111 +++++++++++
 tb/tb_ttlx8_out_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ttlx8_out_stage_if.sv
// Event bus from the real-time output buffer core into the TTL output stage.
interface ttlx8_out_stage_if #(
  parameter int NUM_CH = 8
);
  logic              counter_matched;
  logic [63+NUM_CH:0] rto_out;
  logic              timestamp_error;
  logic              overflow_error;

  modport master (output counter_matched, rto_out, timestamp_error, overflow_error);
  modport slave  (input  counter_matched, rto_out, timestamp_error, overflow_error);
endinterface

// File: rtl/ttlx8_out_stage.sv
// TTL output stage: per-channel level/pulse FSMs, override/invert pin register,
// event counter, last timestamp and sticky buffer error flags.

module ttlx8_ch #(
   parameter int PW_BITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ev,
   input  logic               d,
   input  logic               mask,
   input  logic [PW_BITS-1:0] pw,
   output logic               lvl
);
   typedef enum logic {IDLE, PULSE} state_t;

   state_t             state, state_n;
   logic [PW_BITS-1:0] cnt, cnt_n;
   logic               lvl_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         lvl   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         lvl   <= lvl_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lvl_n   = lvl;
      if (ev) begin
         // An event always wins, so a pulse-mode event in PULSE reloads the count.
         if (d && mask) begin
            lvl_n   = 1'b1;
            cnt_n   = (pw == '0) ? PW_BITS'(1) : pw;
            state_n = PULSE;
         end else begin
            lvl_n   = d;
            cnt_n   = '0;
            state_n = IDLE;
         end
      end else if (state == PULSE) begin
         if (cnt == PW_BITS'(1)) begin
            lvl_n   = 1'b0;
            cnt_n   = '0;
            state_n = IDLE;
         end else begin
            cnt_n = cnt - PW_BITS'(1);
         end
      end
   end
endmodule

module ttlx8_out_stage #(
   parameter int NUM_CH     = 8,
   parameter int PW_BITS    = 16,
   parameter int EVCNT_BITS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   ttlx8_out_stage_if.slave      bus,
   input  logic [NUM_CH-1:0]     pulse_mode_mask,
   input  logic [PW_BITS-1:0]    pulse_width,
   input  logic [NUM_CH-1:0]     override_en,
   input  logic [NUM_CH-1:0]     override_val,
   input  logic [NUM_CH-1:0]     invert,
   input  logic                  error_clear,
   output logic [NUM_CH-1:0]     ttl_out,
   output logic [EVCNT_BITS-1:0] event_count,
   output logic [63:0]           last_timestamp,
   output logic                  ts_err_sticky,
   output logic                  ovf_err_sticky
);
   logic [NUM_CH-1:0] lvl;

   ttlx8_ch #(.PW_BITS(PW_BITS)) u_ch [NUM_CH-1:0] (
      .clk   (clk),
      .reset (reset),
      .ev    (bus.counter_matched),
      .d     (bus.rto_out[NUM_CH-1:0]),
      .mask  (pulse_mode_mask),
      .pw    (pulse_width),
      .lvl   (lvl)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ttl_out        <= '0;
         event_count    <= '0;
         last_timestamp <= '0;
         ts_err_sticky  <= 1'b0;
         ovf_err_sticky <= 1'b0;
      end else begin
         ttl_out <= ((override_en & override_val) | (~override_en & lvl)) ^ invert;
         if (bus.counter_matched) begin
            last_timestamp <= bus.rto_out[63+NUM_CH:NUM_CH];
            if (event_count != '1)
               event_count <= event_count + EVCNT_BITS'(1);
         end
         // Set has priority over clear.
         ts_err_sticky  <= bus.timestamp_error | (ts_err_sticky  & ~error_clear);
         ovf_err_sticky <= bus.overflow_error  | (ovf_err_sticky & ~error_clear);
      end
   end
endmodule

// File: tb/tb_ttlx8_out_stage.sv
// Directed plus random bench for ttlx8_out_stage against a cycle-count model.
module tb_ttlx8_out_stage;
   localparam int NUM_CH = 8;
   localparam int PW_BITS = 16;
   localparam int EVB = 4;      // small counter so saturation is reachable
   localparam int EVMAX = (1 << EVB) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ttlx8_out_stage_if #(.NUM_CH(NUM_CH)) bus ();

   logic [NUM_CH-1:0]  pulse_mode_mask, override_en, override_val, invert;
   logic [PW_BITS-1:0] pulse_width;
   logic               error_clear;
   logic [NUM_CH-1:0]  ttl_out;
   logic [EVB-1:0]     event_count;
   logic [63:0]        last_timestamp;
   logic               ts_err_sticky, ovf_err_sticky;

   ttlx8_out_stage #(.NUM_CH(NUM_CH), .PW_BITS(PW_BITS), .EVCNT_BITS(EVB)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus.slave),
      .pulse_mode_mask (pulse_mode_mask),
      .pulse_width     (pulse_width),
      .override_en     (override_en),
      .override_val    (override_val),
      .invert          (invert),
      .error_clear     (error_clear),
      .ttl_out         (ttl_out),
      .event_count     (event_count),
      .last_timestamp  (last_timestamp),
      .ts_err_sticky   (ts_err_sticky),
      .ovf_err_sticky  (ovf_err_sticky)
   );

   int errors = 0;
   int checks = 0;

   // Model: remaining high cycles per channel, or a held level-mode high.
   int          remain [NUM_CH];
   bit          hold   [NUM_CH];
   logic [7:0]  m_ttl;
   int          m_cnt;
   logic [63:0] m_ts;
   logic        m_tse, m_ovf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin remain[i] = 0; hold[i] = 0; end
      m_ttl = '0; m_cnt = 0; m_ts = '0; m_tse = 0; m_ovf = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else begin
         for (int i = 0; i < NUM_CH; i++) begin
            bit lv;
            lv = hold[i] || (remain[i] > 0);
            m_ttl[i] = (override_en[i] ? override_val[i] : lv) ^ invert[i];
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus.counter_matched) begin
               bit d;
               d = bus.rto_out[i];
               if (d && pulse_mode_mask[i]) begin
                  remain[i] = (pulse_width == 0) ? 1 : int'(pulse_width);
                  hold[i] = 0;
               end else begin
                  remain[i] = 0;
                  hold[i] = d;
               end
            end else if (remain[i] > 0) remain[i]--;
         end
         if (bus.counter_matched) begin
            if (m_cnt < EVMAX) m_cnt++;
            m_ts = bus.rto_out[71:8];
         end
         m_tse = bus.timestamp_error || (m_tse && !error_clear);
         m_ovf = bus.overflow_error  || (m_ovf && !error_clear);
      end
      #1;
      chk("ttl_out", 64'(ttl_out), 64'(m_ttl));
      chk("event_count", 64'(event_count), 64'(m_cnt));
      chk("last_timestamp", last_timestamp, m_ts);
      chk("ts_err_sticky", 64'(ts_err_sticky), 64'(m_tse));
      chk("ovf_err_sticky", 64'(ovf_err_sticky), 64'(m_ovf));
   endtask

   task automatic event_tick(input logic [7:0] d);
      bus.counter_matched = 1'b1;
      bus.rto_out = {$urandom, $urandom, d};
      tick();
      bus.counter_matched = 1'b0;
   endtask

   // Counts ch0 high cycles across the event tick and n following ticks.
   task automatic pulse_len(input logic [15:0] pw, input int n, output int hi);
      pulse_width = pw;
      hi = 0;
      event_tick(8'h01);
      hi += int'(ttl_out[0]);
      for (int k = 0; k < n; k++) begin tick(); hi += int'(ttl_out[0]); end
   endtask

   initial begin
      int hi;
      reset = 1'b1;
      bus.counter_matched = 0; bus.rto_out = '0;
      bus.timestamp_error = 0; bus.overflow_error = 0;
      pulse_mode_mask = '0; pulse_width = '0; override_en = '0; override_val = '0;
      invert = '0; error_clear = 0;
      model_reset();
      tick(); tick();
      chk("reset_ttl", 64'(ttl_out), 64'h0);
      chk("reset_evcnt", 64'(event_count), 64'h0);
      reset = 1'b0;
      tick();

      // Level-mode event
      event_tick(8'hA5);
      chk("t1_ts", last_timestamp, m_ts);
      tick();
      chk("t1_ttl", 64'(ttl_out), 64'hA5);
      event_tick(8'h00); tick();

      // Pulse widths 5 and 0
      pulse_mode_mask = 8'h01;
      pulse_len(16'd5, 12, hi);  chk("pw5_len", 64'(hi), 64'd5);
      pulse_len(16'd0, 6, hi);   chk("pw0_len", 64'(hi), 64'd1);

      // Retrigger at cycle 4 of a 10-cycle pulse
      pulse_width = 16'd10;
      hi = 0;
      event_tick(8'h01); hi += int'(ttl_out[0]);
      for (int k = 0; k < 3; k++) begin tick(); hi += int'(ttl_out[0]); end
      event_tick(8'h01); hi += int'(ttl_out[0]);
      for (int k = 0; k < 16; k++) begin tick(); hi += int'(ttl_out[0]); end
      chk("retrig_len", 64'(hi), 64'd14);

      // data=0 mid-pulse
      event_tick(8'h01); tick(); tick(); tick();
      event_tick(8'h00);
      tick();
      chk("kill_ttl", 64'(ttl_out[0]), 64'd0);

      // Override and invert
      pulse_mode_mask = '0;
      event_tick(8'hFF);
      override_en = 8'hF0; override_val = 8'h30; invert = 8'h0F;
      tick(); tick();
      chk("ovr_ttl", 64'(ttl_out), 64'h30);
      override_en = '0; override_val = '0; invert = '0;
      event_tick(8'h00); tick();

      // Sticky errors
      bus.timestamp_error = 1; error_clear = 1; tick();
      chk("tse_set_wins", 64'(ts_err_sticky), 64'd1);
      bus.timestamp_error = 0; tick();
      chk("tse_cleared", 64'(ts_err_sticky), 64'd0);
      error_clear = 0; bus.overflow_error = 1; tick();
      bus.overflow_error = 0; tick();
      chk("ovf_held", 64'(ovf_err_sticky), 64'd1);
      error_clear = 1; tick(); error_clear = 0;

      // Counter saturation
      for (int k = 0; k < EVMAX + 3; k++) event_tick(8'h00);
      tick();
      chk("evcnt_sat", 64'(event_count), 64'(EVMAX));

      // Reset mid-pulse
      pulse_mode_mask = 8'h01; pulse_width = 16'd10;
      event_tick(8'h01); tick(); tick();
      reset = 1'b1; tick();
      chk("rst_mid_ttl", 64'(ttl_out), 64'h0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("rst_idle_ttl", 64'(ttl_out), 64'h0);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         bus.counter_matched = ($urandom_range(0, 3) == 0);
         bus.rto_out = {$urandom, $urandom, 8'($urandom)};
         pulse_mode_mask = 8'($urandom);
         pulse_width = 16'($urandom_range(0, 6));
         override_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         override_val = 8'($urandom);
         invert = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         bus.timestamp_error = ($urandom_range(0, 7) == 0);
         bus.overflow_error = ($urandom_range(0, 7) == 0);
         error_clear = ($urandom_range(0, 5) == 0);
         reset = ($urandom_range(0, 60) == 0);
         tick();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
